// File: rtl/bimodal_branch_predictor_if.sv
// Fetch-side lookup, execute-side training and table-clear signals of the bimodal predictor.
interface bimodal_branch_predictor_if;
  logic        is_branch;
  logic        is_rv32c;
  logic [31:0] current_pc;
  logic [12:0] imm_sb;
  logic        predict_taken;
  logic [31:0] target_addr;
  logic        pred_hit;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        clear_req;
  logic        clear_busy;

  modport master (
    output is_branch, is_rv32c, current_pc, imm_sb,
    output update_valid, update_pc, update_taken, clear_req,
    input  predict_taken, target_addr, pred_hit, clear_busy
  );

  modport slave (
    input  is_branch, is_rv32c, current_pc, imm_sb,
    input  update_valid, update_pc, update_taken, clear_req,
    output predict_taken, target_addr, pred_hit, clear_busy
  );
endinterface

// File: rtl/bimodal_branch_predictor.sv
// Bimodal branch predictor: tagged saturating-counter table with a static
// backward-taken fallback on misses and a one-entry-per-cycle clear sweep.
module bimodal_branch_predictor #(
  parameter int NENTRIES = 64,
  parameter int CTR_BITS = 2,
  parameter int TAG_BITS = 8
) (
  input logic                     clk,
  input logic                     rst,
  bimodal_branch_predictor_if.slave bp
);
  localparam int IDX = $clog2(NENTRIES);
  localparam logic [CTR_BITS-1:0] WT   = CTR_BITS'(2 ** (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] WNT  = CTR_BITS'(2 ** (CTR_BITS - 1) - 1);
  localparam logic [CTR_BITS-1:0] MAX  = '1;
  localparam logic [CTR_BITS-1:0] ZERO = '0;
  localparam logic [IDX-1:0]      LAST = IDX'(NENTRIES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;

  logic [1:0]                         state;
  logic [IDX-1:0]                     ptr;
  logic [NENTRIES-1:0]                valid_mem;
  logic [NENTRIES-1:0][TAG_BITS-1:0]  tag_mem;
  logic [NENTRIES-1:0][CTR_BITS-1:0]  ctr_mem;

  logic [IDX-1:0]      look_idx;
  logic [TAG_BITS-1:0] look_tag;
  logic                look_hit;
  logic [IDX-1:0]      upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_hit;
  logic [CTR_BITS-1:0] upd_ctr;
  logic [31:0]         branch_offset;
  logic                unused_pc_bits;

  assign look_idx = bp.current_pc[IDX:1];
  assign look_tag = bp.current_pc[IDX+TAG_BITS:IDX+1];
  assign upd_idx  = bp.update_pc[IDX:1];
  assign upd_tag  = bp.update_pc[IDX+TAG_BITS:IDX+1];
  assign upd_ctr  = ctr_mem[upd_idx];
  assign unused_pc_bits = ^{bp.update_pc[0], bp.update_pc[31:IDX+TAG_BITS+1]};

  // Fetch-side lookup and next-PC selection; the table is bypassed during a sweep.
  always_comb begin
    look_hit         = (state == IDLE) && valid_mem[look_idx] && (tag_mem[look_idx] == look_tag);
    branch_offset    = {{19{bp.imm_sb[12]}}, bp.imm_sb};
    bp.pred_hit      = bp.is_branch && look_hit;
    bp.predict_taken = bp.is_branch &&
                       (look_hit ? ctr_mem[look_idx][CTR_BITS-1] : bp.imm_sb[12]);
    if (bp.predict_taken) begin
      bp.target_addr = bp.current_pc + branch_offset;
    end else begin
      bp.target_addr = bp.current_pc + (bp.is_rv32c ? 32'd2 : 32'd4);
    end
    bp.clear_busy    = (state == CLEAR);
  end

  assign upd_hit = valid_mem[upd_idx] && (tag_mem[upd_idx] == upd_tag);

  // Table training in IDLE, invalidation sweep in CLEAR; a clear request beats a same-cycle update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      valid_mem <= '0;
      tag_mem   <= '0;
      ctr_mem   <= {NENTRIES{WNT}};
    end else begin
      case (state)
        IDLE: begin
          if (bp.clear_req) begin
            state <= CLEAR;
            ptr   <= '0;
          end else if (bp.update_valid) begin
            if (upd_hit) begin
              if (bp.update_taken && upd_ctr != MAX) begin
                ctr_mem[upd_idx] <= upd_ctr + 1'b1;
              end else if (!bp.update_taken && upd_ctr != ZERO) begin
                ctr_mem[upd_idx] <= upd_ctr - 1'b1;
              end
            end else begin
              valid_mem[upd_idx] <= 1'b1;
              tag_mem[upd_idx]   <= upd_tag;
              ctr_mem[upd_idx]   <= bp.update_taken ? WT : WNT;
            end
          end
        end
        CLEAR: begin
          valid_mem[ptr] <= 1'b0;
          ctr_mem[ptr]   <= WNT;
          if (bp.clear_req) begin
            ptr <= '0;
          end else if (ptr == LAST) begin
            ptr   <= '0;
            state <= IDLE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bimodal_branch_predictor.sv
// Directed self-checking bench for bimodal_branch_predictor (64 entries, 2-bit counters, 8-bit tags).
module tb_bimodal_branch_predictor;
  logic clk;
  logic rst;
  int   num_compared;
  int   num_mismatched;

  bimodal_branch_predictor_if bp();

  bimodal_branch_predictor dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic br, input logic c, input logic [31:0] pc, input logic [12:0] imm);
    bp.is_branch  = br;
    bp.is_rv32c   = c;
    bp.current_pc = pc;
    bp.imm_sb     = imm;
    #1;
  endtask

  task automatic expectLookup(input string tag, input logic taken, input logic [31:0] target, input logic hit);
    checkOutput({tag, ".taken"},  {31'd0, bp.predict_taken}, {31'd0, taken});
    checkOutput({tag, ".target"}, bp.target_addr, target);
    checkOutput({tag, ".hit"},    {31'd0, bp.pred_hit}, {31'd0, hit});
  endtask

  task automatic doUpdate(input logic [31:0] pc, input logic taken);
    bp.update_valid = 1'b1;
    bp.update_pc    = pc;
    bp.update_taken = taken;
    step();
    bp.update_valid = 1'b0;
  endtask

  task automatic pulseClear();
    bp.clear_req = 1'b1;
    step();
    bp.clear_req = 1'b0;
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (bp.clear_busy && n < 200) begin
      n++;
      step();
    end
  endtask

  // Directed test sequence.
  initial begin
    int n;
    num_compared    = 0;
    num_mismatched  = 0;
    rst             = 1'b1;
    bp.is_branch    = 1'b0;
    bp.is_rv32c     = 1'b0;
    bp.current_pc   = 32'h0;
    bp.imm_sb       = 13'h0;
    bp.update_valid = 1'b0;
    bp.update_pc    = 32'h0;
    bp.update_taken = 1'b0;
    bp.clear_req    = 1'b0;
    step();
    step();
    checkOutput("reset.busy", {31'd0, bp.clear_busy}, 32'd0);
    rst = 1'b0;
    step();

    applyStimulus(1'b1, 1'b0, 32'h100, 13'h1FF8);
    expectLookup("static.back", 1'b1, 32'h0F8, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h100, 13'h0008);
    expectLookup("static.fwd_c", 1'b0, 32'h102, 1'b0);

    applyStimulus(1'b1, 1'b0, 32'h200, 13'h0010);
    doUpdate(32'h200, 1'b1);
    expectLookup("train.alloc_wt", 1'b1, 32'h210, 1'b1);
    doUpdate(32'h200, 1'b1);
    doUpdate(32'h200, 1'b1);
    expectLookup("train.sat3", 1'b1, 32'h210, 1'b1);
    doUpdate(32'h200, 1'b0);
    expectLookup("train.ctr2", 1'b1, 32'h210, 1'b1);
    doUpdate(32'h200, 1'b0);
    expectLookup("train.ctr1", 1'b0, 32'h204, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h200, 13'h0010);
    expectLookup("train.not_branch", 1'b0, 32'h204, 1'b0);

    applyStimulus(1'b1, 1'b0, 32'h280, 13'h1FF8);
    expectLookup("alias.miss", 1'b1, 32'h278, 1'b0);
    doUpdate(32'h280, 1'b0);
    expectLookup("alias.alloc_wnt", 1'b0, 32'h284, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h200, 13'h1FF8);
    expectLookup("alias.evicted", 1'b1, 32'h1F8, 1'b0);

    applyStimulus(1'b1, 1'b0, 32'h280, 13'h0008);
    bp.update_valid = 1'b1;
    bp.update_pc    = 32'h280;
    bp.update_taken = 1'b1;
    #1;
    expectLookup("bypass.old", 1'b0, 32'h284, 1'b1);
    step();
    bp.update_valid = 1'b0;
    #1;
    expectLookup("bypass.new", 1'b1, 32'h288, 1'b1);

    doUpdate(32'h204, 1'b1);
    doUpdate(32'h208, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h208, 13'h0008);
    expectLookup("pre_clear", 1'b1, 32'h210, 1'b1);
    pulseClear();
    checkOutput("clear.busy_start", {31'd0, bp.clear_busy}, 32'd1);
    expectLookup("clear.lookup_miss", 1'b0, 32'h20C, 1'b0);
    n = 0;
    while (bp.clear_busy && n < 200) begin
      n++;
      bp.update_valid = (n == 10);
      bp.update_pc    = 32'h20C;
      bp.update_taken = 1'b1;
      step();
    end
    bp.update_valid = 1'b0;
    checkOutput("clear.busy_cycles", n, 32'd64);
    applyStimulus(1'b1, 1'b0, 32'h204, 13'h0008);
    expectLookup("after.204", 1'b0, 32'h208, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h280, 13'h0008);
    expectLookup("after.280", 1'b0, 32'h284, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h20C, 13'h0008);
    expectLookup("after.dropped_upd", 1'b0, 32'h210, 1'b0);

    bp.update_valid = 1'b1;
    bp.update_pc    = 32'h210;
    bp.update_taken = 1'b1;
    pulseClear();
    bp.update_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    checkOutput("restart.busy_mid", {31'd0, bp.clear_busy}, 32'd1);
    pulseClear();
    countBusy(n);
    checkOutput("restart.busy_cycles", n, 32'd64);
    applyStimulus(1'b1, 1'b0, 32'h210, 13'h0008);
    expectLookup("restart.clear_wins", 1'b0, 32'h214, 1'b0);

    doUpdate(32'h204, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h204, 13'h0008);
    expectLookup("rst.pre", 1'b1, 32'h20C, 1'b1);
    pulseClear();
    for (int i = 0; i < 5; i++) step();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst.busy_async", {31'd0, bp.clear_busy}, 32'd0);
    step();
    #2;
    rst = 1'b0;
    step();
    checkOutput("rst.busy_after", {31'd0, bp.clear_busy}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h204, 13'h0008);
    expectLookup("rst.table_invalid", 1'b0, 32'h208, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end
endmodule
